// File: rtl/multiplier_control_if.sv
// Strobe/handshake bundle between the multiplier sequencer and its host/Product register.
// master = host side (drives run, returns prod_lsb); slave = sequencer side.
interface multiplier_control_if;
    logic run;
    logic prod_lsb;
    logic prod_load;
    logic w_ctrl;
    logic srl_ctrl;
    logic ready;

    modport master (
        output run,
        output prod_lsb,
        input  prod_load,
        input  w_ctrl,
        input  srl_ctrl,
        input  ready
    );

    modport slave (
        input  run,
        input  prod_lsb,
        output prod_load,
        output w_ctrl,
        output srl_ctrl,
        output ready
    );
endinterface

// File: rtl/multiplier_control.sv
// Shift-add multiplier sequencer: LOAD, then WIDTH check/shift iterations, then DONE with ready held.
// Define MULT_FUSED_EN to merge CHECK and SHIFT into a single ITER state (write and shift on one edge).
module multiplier_control #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    multiplier_control_if.slave ctrl
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4,
        S_ITER  = 3'd5
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_iter;
    logic          r_prod_load;
    logic          r_wen;
    logic          r_srl;
    logic          r_ready;

    // Output flags are registered alongside the state they decode, so they stay
    // Moore outputs; only the write strobe is gated by the live product LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_iter      <= '0;
            r_prod_load <= 1'b0;
            r_wen       <= 1'b0;
            r_srl       <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_prod_load <= 1'b0;
            r_wen       <= 1'b0;
            r_srl       <= 1'b0;
            r_ready     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctrl.run) begin
                        r_state     <= S_LOAD;
                        r_prod_load <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_iter <= '0;
`ifdef MULT_FUSED_EN
                    r_state <= S_ITER;
                    r_wen   <= 1'b1;
                    r_srl   <= 1'b1;
`else
                    r_state <= S_CHECK;
                    r_wen   <= 1'b1;
`endif
                end
`ifdef MULT_FUSED_EN
                S_ITER: begin
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == LAST) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end else begin
                        r_wen <= 1'b1;
                        r_srl <= 1'b1;
                    end
                end
`else
                S_CHECK: begin
                    r_state <= S_SHIFT;
                    r_srl   <= 1'b1;
                end
                S_SHIFT: begin
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == LAST) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_CHECK;
                        r_wen   <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (ctrl.run) begin
                        r_state     <= S_LOAD;
                        r_prod_load <= 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ctrl.prod_load = r_prod_load;
    assign ctrl.w_ctrl    = r_wen & ctrl.prod_lsb;
    assign ctrl.srl_ctrl  = r_srl;
    assign ctrl.ready     = r_ready;

endmodule

// File: tb/tb_multiplier_control.sv
// Scoreboard bench for multiplier_control: a 32-bit and a 4-bit instance each drive a behavioural
// Product register; expected per-operation results are queued at issue and checked when ready rises.
module tb_multiplier_control;

    localparam int unsigned WA = 32;
    localparam int unsigned WB = 4;
`ifdef MULT_FUSED_EN
    localparam bit          FUSED = 1'b1;
    localparam int unsigned LAT_A = 33;
    localparam int unsigned LAT_B = 5;
`else
    localparam bit          FUSED = 1'b0;
    localparam int unsigned LAT_A = 65;
    localparam int unsigned LAT_B = 9;
`endif

    typedef struct {
        int unsigned lat;
        int unsigned wcnt;
        int unsigned scnt;
        int unsigned both;
        logic [31:0] mask;
        logic [63:0] prod;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multiplier_control_if bus_a ();
    multiplier_control_if bus_b ();

    multiplier_control #(.WIDTH(WA)) dut_a (.clk(clk), .reset(reset), .ctrl(bus_a.slave));
    multiplier_control #(.WIDTH(WB)) dut_b (.clk(clk), .reset(reset), .ctrl(bus_b.slave));

    exp_t        q_a[$];
    exp_t        q_b[$];
    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    logic [31:0]   mult_a = '0, mcand_a = '0, mult_b = '0, mcand_b = '0;
    logic [2*WA:0] pa = '0;
    logic [2*WB:0] pb = '0;

    function automatic logic [2*WA:0] step_a(input logic [2*WA:0] p, input logic [WA-1:0] m,
                                             input logic w, input logic s);
        logic [2*WA:0] r;
        r = p;
        if (w) r[2*WA:WA] = {1'b0, p[2*WA-1:WA]} + {1'b0, m};
        if (s) r = r >> 1;
        return r;
    endfunction

    function automatic logic [2*WB:0] step_b(input logic [2*WB:0] p, input logic [WB-1:0] m,
                                             input logic w, input logic s);
        logic [2*WB:0] r;
        r = p;
        if (w) r[2*WB:WB] = {1'b0, p[2*WB-1:WB]} + {1'b0, m};
        if (s) r = r >> 1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus_a.prod_load) pa <= {{(WA+1){1'b0}}, mult_a[WA-1:0]};
        else                 pa <= step_a(pa, mcand_a[WA-1:0], bus_a.w_ctrl, bus_a.srl_ctrl);
        if (bus_b.prod_load) pb <= {{(WB+1){1'b0}}, mult_b[WB-1:0]};
        else                 pb <= step_b(pb, mcand_b[WB-1:0], bus_b.w_ctrl, bus_b.srl_ctrl);
    end

    assign bus_a.prod_lsb = pa[0];
    assign bus_b.prod_lsb = pb[0];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned qsize(input int id);
        return (id == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic monitor(input int id);
        int unsigned cyc, wc, sc, bc;
        logic [31:0] mask;
        logic        act, ovl, ld, w, s, rd;
        logic [63:0] prod;
        exp_t        e;
        string       t;
        act = 1'b0; cyc = 0; wc = 0; sc = 0; bc = 0; mask = '0; ovl = 1'b0;
        t = (id == 0) ? "A" : "B";
        forever begin
            @(negedge clk);
            if (id == 0) begin
                ld = bus_a.prod_load; w = bus_a.w_ctrl; s = bus_a.srl_ctrl; rd = bus_a.ready;
                prod = 64'(pa[2*WA-1:0]);
            end else begin
                ld = bus_b.prod_load; w = bus_b.w_ctrl; s = bus_b.srl_ctrl; rd = bus_b.ready;
                prod = 64'(pb[2*WB-1:0]);
            end
            if (!reset) begin
                act = 1'b0;
            end else if (ld) begin
                act = 1'b1; cyc = 0; wc = 0; sc = 0; bc = 0; mask = '0; ovl = w | s;
            end else if (act) begin
                cyc++;
                if (w && s) bc++;
                if (w) begin
                    wc++;
                    if (sc < 32) mask[sc] = 1'b1;
                end
                if (s) sc++;
                if (rd) begin
                    act = 1'b0;
                    chk({t, ".queue_nonempty"}, 64'(qsize(id) != 0), 64'd1);
                    if (qsize(id) != 0) begin
                        e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                        chk({t, ".latency"},    64'(cyc),  64'(e.lat));
                        chk({t, ".w_pulses"},   64'(wc),   64'(e.wcnt));
                        chk({t, ".srl_pulses"}, 64'(sc),   64'(e.scnt));
                        chk({t, ".w_and_srl"},  64'(bc),   64'(e.both));
                        chk({t, ".w_iter_mask"},64'(mask), 64'(e.mask));
                        chk({t, ".load_ovl"},   64'(ovl),  64'd0);
                        chk({t, ".product"},    prod,      e.prod);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic push_exp(input int id, input logic [31:0] m, input int unsigned pop,
                            input logic [63:0] prod);
        exp_t e;
        e.lat  = (id == 0) ? LAT_A : LAT_B;
        e.wcnt = pop;
        e.scnt = (id == 0) ? WA : WB;
        e.both = FUSED ? pop : 0;
        e.mask = m;
        e.prod = prod;
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endtask

    task automatic issue(input int id, input logic [31:0] m, input logic [31:0] mc,
                         input int unsigned pop, input logic [63:0] prod, input bit push);
        if (id == 0) begin mult_a = m; mcand_a = mc; end
        else         begin mult_b = m; mcand_b = mc; end
        if (push) push_exp(id, m, pop, prod);
        @(negedge clk);
        if (id == 0) bus_a.run = 1'b1; else bus_b.run = 1'b1;
        @(negedge clk);
        if (id == 0) bus_a.run = 1'b0; else bus_b.run = 1'b0;
    endtask

    task automatic drain(input int id, input int unsigned budget);
        int unsigned k;
        k = 0;
        while (qsize(id) != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("drain%0d pending", id), 64'(qsize(id)), 64'd0);
    endtask

    initial begin
        int unsigned k;
        bus_a.run = 1'b0;
        bus_b.run = 1'b0;

        // asynchronous reset before the first clock edge
        #3 reset = 1'b0;
        #1;
        chk("rst A outs", 64'({bus_a.prod_load, bus_a.w_ctrl, bus_a.srl_ctrl, bus_a.ready}), 64'd0);
        chk("rst B outs", 64'({bus_b.prod_load, bus_b.w_ctrl, bus_b.srl_ctrl, bus_b.ready}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle A outs", 64'({bus_a.prod_load, bus_a.w_ctrl, bus_a.srl_ctrl, bus_a.ready}), 64'd0);

        // all-ones multiplier, multiplicand 10
        issue(0, 32'hFFFF_FFFF, 32'd10, 32, 64'h9_FFFF_FFF6, 1'b1);
        drain(0, 200);

        // 4-bit 1010 x 3, then zero multiplier
        issue(1, 32'hA, 32'd3, 2, 64'h1E, 1'b1);
        drain(1, 50);
        issue(1, 32'h0, 32'd9, 0, 64'h0, 1'b1);
        drain(1, 50);

        // run held high: back-to-back ops, DONE lasts exactly one cycle
        mult_b  = 32'hF;
        mcand_b = 32'd15;
        push_exp(1, 32'hF, 4, 64'hE1);
        push_exp(1, 32'hF, 4, 64'hE1);
        @(negedge clk);
        bus_b.run = 1'b1;
        k = 0;
        while (!bus_b.prod_load && k < 10) begin @(negedge clk); k++; end
        @(negedge clk);
        k = 0;
        while (!bus_b.ready && k < 40) begin @(negedge clk); k++; end
        chk("held ready seen", 64'(bus_b.ready), 64'd1);
        @(negedge clk);
        chk("held done->load", 64'({bus_b.ready, bus_b.prod_load}), 64'b01);
        bus_b.run = 1'b0;
        drain(1, 50);
        repeat (3) @(negedge clk);
        chk("done holds ready", 64'(bus_b.ready), 64'd1);

        // abort during iteration 5 of a 32-bit op (SHIFT cycle), then full rerun
        issue(0, 32'h3, 32'd7, 2, 64'd21, 1'b0);
        repeat (12) @(negedge clk);
        chk("pre-abort srl", 64'(bus_a.srl_ctrl), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort A outs", 64'({bus_a.prod_load, bus_a.w_ctrl, bus_a.srl_ctrl, bus_a.ready}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post-abort idle", 64'({bus_a.prod_load, bus_a.srl_ctrl, bus_a.ready}), 64'd0);
        issue(0, 32'h3, 32'd7, 2, 64'd21, 1'b1);
        drain(0, 200);

        // single set bit: one write (fused build writes and shifts together)
        issue(0, 32'h1, 32'hDEAD_BEEF, 1, 64'hDEAD_BEEF, 1'b1);
        drain(0, 200);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
